fix_session_timer: RTL and testbench
====================================

Name: fix_session_timer

Overview:
Multi-host FIX session liveness engine. It replaces the session manager's hardwired timeout_i.
- Keeps per-host tx/rx idle timers in seconds, derived from an internal clk prescaler.
- Raises HEARTBEAT, TEST_REQUEST and TIMEOUT requests per FIX heartbeat rules.
- Arbitrates the requests round-robin onto one valid/ready channel toward the session manager / create_message path.

Parameters:
NUM_HOST, 8, number of concurrent host sessions
HOST_ADDR_WIDTH, 3, host index width; must equal clog2(NUM_HOST)
TICK_DIV, 1000, clk cycles per one-second tick (>=2)
HB_WIDTH, 8, width of interval and per-host second counters
GRACE, 1, extra seconds allowed past interval before a TEST_REQUEST is raised

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
session_up_i  in  NUM_HOST  per-host level; 1 = logged on
hb_interval_i  in  HB_WIDTH  heartbeat interval in seconds, common to all hosts; 0 disables all timers
rx_msg_i  in  1  one-cycle pulse: any inbound message for rx_host_i
rx_host_i  in  HOST_ADDR_WIDTH  host of inbound message
tx_msg_i  in  1  one-cycle pulse: any outbound message for tx_host_i
tx_host_i  in  HOST_ADDR_WIDTH  host of outbound message
req_valid_o  out  1  request presented
req_type_o  out  2  1=HEARTBEAT, 2=TEST_REQUEST, 3=TIMEOUT (0 never presented while valid)
req_host_o  out  HOST_ADDR_WIDTH  target host
req_ready_i  in  1  consumer accepts when req_valid_o & req_ready_i
sec_tick_o  out  1  one-cycle second tick (debug/bench)
timed_out_o  out  NUM_HOST  per-host level; 1 while in TIMED_OUT

Behaviour:
- Reset (async, rst=1): every output is 0, all hosts are in IDLE, all counters and pending flags are 0, and the round-robin pointer is 0.
- Prescaler: counts 0..TICK_DIV-1. sec_tick_o=1 for the single cycle in which the count is TICK_DIV-1, then the count wraps to 0.
- Per-host state machine (registered):
  - IDLE: counters held at 0. Goes to ACTIVE when session_up_i[h]=1.
  - ACTIVE: on a tick, tx_cnt and rx_cnt each increment, saturating at all-ones.
    - tx_cnt reaching hb_interval_i sets hb_pend and clears tx_cnt.
    - rx_cnt reaching hb_interval_i+GRACE sets tr_pend, clears rx_cnt, and moves the host to TEST_SENT.
  - TEST_SENT: an rx pulse returns the host to ACTIVE. rx_cnt reaching hb_interval_i sets to_pend and moves the host to TIMED_OUT. Heartbeat logic continues as in ACTIVE.
  - TIMED_OUT: counters frozen, hb_pend and tr_pend cleared, timed_out_o[h]=1. Goes to IDLE only when session_up_i[h]=0.
  - Any state goes to IDLE when session_up_i[h]=0. This clears all flags and counters for that host.
- Counter resets:
  - An rx pulse for h clears rx_cnt[h].
  - A tx pulse for h, or an accepted HEARTBEAT/TEST_REQUEST for h, clears tx_cnt[h] and hb_pend[h].
  - When a pulse and a tick hit the same host in the same cycle, the clear wins and there is no increment.
- Interval: hb_interval_i=0 means no increments and no new pend flags; existing flags remain. The interval is compared live each tick, so a change takes effect on the next tick.
- Arbitration:
  - Within a host, priority is to_pend > tr_pend > hb_pend.
  - Across hosts, round-robin: the search starts at (last granted host + 1) mod NUM_HOST.
  - The output register loads only when req_valid_o=0, or in the same cycle as an acceptance (back-to-back is allowed).
  - Payload is held stable until accepted, even if the host's session drops; the consumer discards it.
  - Acceptance clears the corresponding pend flag.
  - A HEARTBEAT still pending when the same host gains tr_pend is merged: only TEST_REQUEST is sent, and its acceptance also clears hb_pend.
- Latency: pend flags are set at the end of the tick cycle T. With the output idle, req_valid_o is 1 from cycle T+2.
- Pend flags are sticky: a second threshold before acceptance does not queue a duplicate.

Decomposition:
- Package fix_timer_pkg holds:
  - req_type_t enum: REQ_NONE, REQ_HB, REQ_TR, REQ_TO.
  - host_state_t enum: IDLE, ACTIVE, TEST_SENT, TIMED_OUT.
  - Default TICK_DIV and GRACE constants.
- Sub-module fix_host_timer: one host's state machine, counters and pend flags. It is instantiated NUM_HOST times via generate.
- The prescaler and round-robin arbiter stay in the top module.

Test Plan:
- Heartbeat: TICK_DIV=4, interval=3, host 2 up, no traffic. A HEARTBEAT for host 2 is valid 2 cycles after the 3rd tick. Hold ready=0 for 5 cycles: the payload stays stable. After acceptance, the next HEARTBEAT comes 3 ticks later.
- Test request / timeout: host 1 up, no rx. At tick 3 a HEARTBEAT is raised and accepted. At tick 4 (3+GRACE) a TEST_REQUEST is raised. With no rx for 3 more ticks, TIMEOUT is raised and timed_out_o[1]=1. Dropping session_up_i[1] clears it.
- Recovery: as above, but an rx pulse for host 1 arrives one tick after the TEST_REQUEST. No TIMEOUT occurs, and the host behaves as ACTIVE with rx_cnt=0.
- Round-robin: hosts 0, 1 and 3 all hit heartbeat on the same tick with ready=1 constantly. Grants go to host 0, 1, 3 on consecutive cycles. Repeat with pointer=1: order is 1, 3, 0.
- Collisions: a tx pulse for host 0 in the exact tick cycle where tx_cnt would reach the interval gives no HEARTBEAT and tx_cnt=0. hb_interval_i=0 gives no requests for 20 ticks.
- Reset mid-request: assert rst while req_valid_o=1. All outputs go to 0 immediately, and no request appears until the interval has elapsed again after rst falls.

Source files
------------

// File: rtl/fix_timer_pkg.sv
`default_nettype none
// ============================================================================
// fix_timer_pkg : shared types and defaults for the FIX session liveness engine
// Revision      : 1.0
// ============================================================================
package fix_timer_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_HB   = 2'd1,
        REQ_TR   = 2'd2,
        REQ_TO   = 2'd3
    } req_type_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        TEST_SENT = 2'd2,
        TIMED_OUT = 2'd3
    } host_state_t;

    localparam int c_DEFAULT_TICK_DIV = 1000;
    localparam int c_DEFAULT_GRACE    = 1;

endpackage
`default_nettype wire

// File: rtl/fix_host_timer.sv
`default_nettype none
// ============================================================================
// fix_host_timer : one host's liveness FSM, tx/rx idle counters and pend flags
// Revision       : 1.0
// ============================================================================
module fix_host_timer
    import fix_timer_pkg::*;
#(
    parameter int HB_WIDTH = 8,
    parameter int GRACE    = c_DEFAULT_GRACE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_i,
    input  logic [HB_WIDTH-1:0] interval_i,
    input  logic                tick_i,
    input  logic                rx_i,
    input  logic                tx_i,
    input  logic                acc_hb_i,
    input  logic                acc_tr_i,
    input  logic                acc_to_i,
    output logic                hb_pend_o,
    output logic                tr_pend_o,
    output logic                to_pend_o,
    output logic                timed_out_o
);

    host_state_t         state_q, state_d;
    logic [HB_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [HB_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic                hb_pend_q, hb_pend_d;
    logic                tr_pend_q, tr_pend_d;
    logic                to_pend_q, to_pend_d;

    logic [HB_WIDTH:0]   w_thr_wide;
    logic [HB_WIDTH-1:0] w_tr_thr;
    logic [HB_WIDTH-1:0] w_tx_inc;
    logic [HB_WIDTH-1:0] w_rx_inc;
    logic                w_run;

    // Clamp interval+GRACE so a saturated rx counter can still reach it.
    assign w_thr_wide = {1'b0, interval_i} + (HB_WIDTH+1)'(GRACE);
    assign w_tr_thr   = w_thr_wide[HB_WIDTH] ? '1 : w_thr_wide[HB_WIDTH-1:0];
    assign w_tx_inc   = (tx_cnt_q == '1) ? tx_cnt_q : tx_cnt_q + 1'b1;
    assign w_rx_inc   = (rx_cnt_q == '1) ? rx_cnt_q : rx_cnt_q + 1'b1;
    assign w_run      = tick_i && (interval_i != '0);

    always_comb begin
        state_d   = state_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        hb_pend_d = hb_pend_q;
        tr_pend_d = tr_pend_q & ~acc_tr_i;
        to_pend_d = to_pend_q & ~acc_to_i;
        case (state_q)
            IDLE: begin
                tx_cnt_d  = '0;
                rx_cnt_d  = '0;
                hb_pend_d = 1'b0;
                tr_pend_d = 1'b0;
                to_pend_d = 1'b0;
                if (up_i) state_d = ACTIVE;
            end
            ACTIVE, TEST_SENT: begin
                if (tx_i || acc_hb_i) begin
                    tx_cnt_d  = '0;
                    hb_pend_d = 1'b0;
                end else if (w_run) begin
                    if (w_tx_inc >= interval_i) begin
                        tx_cnt_d  = '0;
                        hb_pend_d = 1'b1;
                    end else begin
                        tx_cnt_d = w_tx_inc;
                    end
                end
                if (rx_i) begin
                    rx_cnt_d = '0;
                    state_d  = ACTIVE;
                end else if (w_run) begin
                    if (state_q == ACTIVE && w_rx_inc >= w_tr_thr) begin
                        rx_cnt_d  = '0;
                        tr_pend_d = 1'b1;
                        state_d   = TEST_SENT;
                    end else if (state_q == TEST_SENT && w_rx_inc >= interval_i) begin
                        to_pend_d = 1'b1;
                        hb_pend_d = 1'b0;
                        tr_pend_d = 1'b0;
                        state_d   = TIMED_OUT;
                    end else begin
                        rx_cnt_d = w_rx_inc;
                    end
                end
            end
            TIMED_OUT: begin
                hb_pend_d = 1'b0;
                tr_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Session drop overrides everything, including a timeout in flight.
        if (!up_i) begin
            state_d   = IDLE;
            tx_cnt_d  = '0;
            rx_cnt_d  = '0;
            hb_pend_d = 1'b0;
            tr_pend_d = 1'b0;
            to_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            hb_pend_q <= 1'b0;
            tr_pend_q <= 1'b0;
            to_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            hb_pend_q <= hb_pend_d;
            tr_pend_q <= tr_pend_d;
            to_pend_q <= to_pend_d;
        end
    end

    assign hb_pend_o   = hb_pend_q;
    assign tr_pend_o   = tr_pend_q;
    assign to_pend_o   = to_pend_q;
    assign timed_out_o = (state_q == TIMED_OUT);

endmodule
`default_nettype wire

// File: rtl/fix_session_timer.sv
`default_nettype none
// ============================================================================
// fix_session_timer : multi-host FIX heartbeat/test-request/timeout engine
// Revision          : 1.0
// ============================================================================
module fix_session_timer
    import fix_timer_pkg::*;
#(
    parameter int NUM_HOST        = 8,
    parameter int HOST_ADDR_WIDTH = 3,
    parameter int TICK_DIV        = c_DEFAULT_TICK_DIV,
    parameter int HB_WIDTH        = 8,
    parameter int GRACE           = c_DEFAULT_GRACE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_HOST-1:0]        session_up_i,
    input  logic [HB_WIDTH-1:0]        hb_interval_i,
    input  logic                       rx_msg_i,
    input  logic [HOST_ADDR_WIDTH-1:0] rx_host_i,
    input  logic                       tx_msg_i,
    input  logic [HOST_ADDR_WIDTH-1:0] tx_host_i,
    output logic                       req_valid_o,
    output logic [1:0]                 req_type_o,
    output logic [HOST_ADDR_WIDTH-1:0] req_host_o,
    input  logic                       req_ready_i,
    output logic                       sec_tick_o,
    output logic [NUM_HOST-1:0]        timed_out_o
);

    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_AW = HOST_ADDR_WIDTH + 1;

    logic [c_PW-1:0]            presc_q;
    logic                       w_tick;

    logic                       req_valid_q;
    req_type_t                  req_type_q;
    logic [HOST_ADDR_WIDTH-1:0] req_host_q;
    logic [HOST_ADDR_WIDTH-1:0] rr_ptr_q;

    logic [NUM_HOST-1:0]        w_hb_avail, w_tr_avail, w_to_avail, w_any;
    logic                       w_accept, w_load, w_found;
    req_type_t                  w_sel_type;
    logic [HOST_ADDR_WIDTH-1:0] w_sel_host, w_rr_idx, w_ptr_next;
    logic [c_AW-1:0]            w_rr_sum;

    assign w_tick     = (presc_q == c_PW'(TICK_DIV - 1));
    assign sec_tick_o = w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         presc_q <= '0;
        else if (w_tick) presc_q <= '0;
        else             presc_q <= presc_q + 1'b1;
    end

    assign w_accept = req_valid_q & req_ready_i;
    assign w_load   = ~req_valid_q | req_ready_i;

    generate
        for (genvar h = 0; h < NUM_HOST; h++) begin : g_host
            logic w_acc_here, w_acc_hb, w_acc_tr, w_acc_to;
            logic w_hb, w_tr, w_to;

            assign w_acc_here = w_accept && (req_host_q == HOST_ADDR_WIDTH'(h));
            assign w_acc_hb   = w_acc_here && (req_type_q == REQ_HB || req_type_q == REQ_TR);
            assign w_acc_tr   = w_acc_here && (req_type_q == REQ_TR);
            assign w_acc_to   = w_acc_here && (req_type_q == REQ_TO);

            fix_host_timer #(
                .HB_WIDTH (HB_WIDTH),
                .GRACE    (GRACE)
            ) u_host (
                .clk         (clk),
                .rst         (rst),
                .up_i        (session_up_i[h]),
                .interval_i  (hb_interval_i),
                .tick_i      (w_tick),
                .rx_i        (rx_msg_i && (rx_host_i == HOST_ADDR_WIDTH'(h))),
                .tx_i        (tx_msg_i && (tx_host_i == HOST_ADDR_WIDTH'(h))),
                .acc_hb_i    (w_acc_hb),
                .acc_tr_i    (w_acc_tr),
                .acc_to_i    (w_acc_to),
                .hb_pend_o   (w_hb),
                .tr_pend_o   (w_tr),
                .to_pend_o   (w_to),
                .timed_out_o (timed_out_o[h])
            );

            // Hide flags being cleared by this cycle's acceptance so a
            // back-to-back load never re-sends the request just consumed.
            assign w_hb_avail[h] = w_hb & ~w_acc_hb;
            assign w_tr_avail[h] = w_tr & ~w_acc_tr;
            assign w_to_avail[h] = w_to & ~w_acc_to;
            assign w_any[h]      = w_hb_avail[h] | w_tr_avail[h] | w_to_avail[h];
        end
    endgenerate

    always_comb begin
        w_found    = 1'b0;
        w_sel_host = '0;
        w_sel_type = REQ_NONE;
        w_rr_sum   = '0;
        w_rr_idx   = '0;
        for (int i = 0; i < NUM_HOST; i++) begin
            w_rr_sum = {1'b0, rr_ptr_q} + c_AW'(i);
            if (w_rr_sum >= c_AW'(NUM_HOST)) w_rr_sum = w_rr_sum - c_AW'(NUM_HOST);
            w_rr_idx = w_rr_sum[HOST_ADDR_WIDTH-1:0];
            if (!w_found && w_any[w_rr_idx]) begin
                w_found    = 1'b1;
                w_sel_host = w_rr_idx;
                if (w_to_avail[w_rr_idx])      w_sel_type = REQ_TO;
                else if (w_tr_avail[w_rr_idx]) w_sel_type = REQ_TR;
                else                           w_sel_type = REQ_HB;
            end
        end
    end

    assign w_ptr_next = (w_sel_host == HOST_ADDR_WIDTH'(NUM_HOST - 1)) ? '0 : w_sel_host + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_type_q  <= REQ_NONE;
            req_host_q  <= '0;
            rr_ptr_q    <= '0;
        end else if (w_load) begin
            req_valid_q <= w_found;
            req_type_q  <= w_sel_type;
            req_host_q  <= w_sel_host;
            if (w_found) rr_ptr_q <= w_ptr_next;
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_type_o  = req_type_q;
    assign req_host_o  = req_host_q;

endmodule
`default_nettype wire

// File: tb/tb_fix_session_timer.sv
`default_nettype none
// ============================================================================
// tb_fix_session_timer : directed self-checking bench, TICK_DIV=4, interval=3
// Revision             : 1.0
// ============================================================================
module tb_fix_session_timer;

    logic       clk;
    logic       rst;
    logic [7:0] session_up;
    logic [7:0] hb_interval;
    logic       rx_msg;
    logic [2:0] rx_host;
    logic       tx_msg;
    logic [2:0] tx_host;
    logic       req_valid;
    logic [1:0] req_type;
    logic [2:0] req_host;
    logic       req_ready;
    logic       sec_tick;
    logic [7:0] timed_out;

    int n_tests = 0;
    int n_fail  = 0;

    fix_session_timer #(
        .NUM_HOST        (8),
        .HOST_ADDR_WIDTH (3),
        .TICK_DIV        (4),
        .HB_WIDTH        (8),
        .GRACE           (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .session_up_i  (session_up),
        .hb_interval_i (hb_interval),
        .rx_msg_i      (rx_msg),
        .rx_host_i     (rx_host),
        .tx_msg_i      (tx_msg),
        .tx_host_i     (tx_host),
        .req_valid_o   (req_valid),
        .req_type_o    (req_type),
        .req_host_o    (req_host),
        .req_ready_i   (req_ready),
        .sec_tick_o    (sec_tick),
        .timed_out_o   (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 (want finished)");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Advance to the next negedge at which sec_tick_o is high (bounded).
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (sec_tick) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tick: sec_tick got 0 for 8 cycles, want 1");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; session_up = '0; rx_msg = 1'b0; tx_msg = 1'b0; req_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({req_valid, req_type, req_host, sec_tick, timed_out} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b t=%0d h=%0d tick=%0b to=%h, want all 0",
                     req_valid, req_type, req_host, sec_tick, timed_out);
        end
        step();
        rst = 1'b0;
        step(); step();
        n_tests++;
        if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL presc_cnt2: tick got %0b want 0", sec_tick); end
        step();
        n_tests++;
        if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL presc_cnt3: tick got %0b want 1", sec_tick); end
        step();
        n_tests++;
        if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL presc_wrap: tick got %0b want 0", sec_tick); end
    endtask

    task automatic test_heartbeat();
        do_reset();
        hb_interval = 8'd3;
        wait_tick();
        session_up = 8'b0000_0100;
        wait_tick(); wait_tick(); wait_tick();
        step();
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL hb_t1: valid got %0b want 0", req_valid); end
        step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd2}) begin
            n_fail++;
            $display("FAIL hb_t2: got v=%0b t=%0d h=%0d want v=1 t=1 h=2", req_valid, req_type, req_host);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            rx_msg  = (k == 1);
            rx_host = 3'd2;
            n_tests++;
            if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd2}) begin
                n_fail++;
                $display("FAIL hb_hold%0d: got v=%0b t=%0d h=%0d want v=1 t=1 h=2", k, req_valid, req_type, req_host);
            end
        end
        req_ready = 1'b1;
        step();
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL hb_accepted: valid got %0b want 0", req_valid); end
        rx_msg = 1'b1; rx_host = 3'd2;
        step();
        rx_msg = 1'b0;
        wait_tick();
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL hb_early: valid got %0b want 0", req_valid); end
        wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd2}) begin
            n_fail++;
            $display("FAIL hb_second: got v=%0b t=%0d h=%0d want v=1 t=1 h=2", req_valid, req_type, req_host);
        end
        step();
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL hb_second_acc: valid got %0b want 0", req_valid); end
    endtask

    // Common prefix: host 1 up, HEARTBEAT at tick 3 then TEST_REQUEST at tick 4.
    task automatic host1_to_test_sent(input string tag);
        do_reset();
        hb_interval = 8'd3;
        req_ready = 1'b1;
        wait_tick();
        session_up = 8'b0000_0010;
        wait_tick(); wait_tick(); wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd1}) begin
            n_fail++;
            $display("FAIL %s_hb: got v=%0b t=%0d h=%0d want v=1 t=1 h=1", tag, req_valid, req_type, req_host);
        end
        wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL %s_tr: got v=%0b t=%0d h=%0d want v=1 t=2 h=1", tag, req_valid, req_type, req_host);
        end
        step();
    endtask

    task automatic test_timeout();
        host1_to_test_sent("to");
        wait_tick(); wait_tick(); wait_tick();
        n_tests++;
        if (timed_out !== 8'h00) begin n_fail++; $display("FAIL to_before: timed_out got %h want 00", timed_out); end
        step();
        n_tests++;
        if (timed_out !== 8'h02) begin n_fail++; $display("FAIL to_level: timed_out got %h want 02", timed_out); end
        step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd3, 3'd1}) begin
            n_fail++;
            $display("FAIL to_req: got v=%0b t=%0d h=%0d want v=1 t=3 h=1", req_valid, req_type, req_host);
        end
        step();
        n_tests++;
        if ({req_valid, timed_out} !== {1'b0, 8'h02}) begin
            n_fail++;
            $display("FAIL to_after_acc: got v=%0b to=%h want v=0 to=02", req_valid, timed_out);
        end
        session_up = 8'h00;
        step();
        n_tests++;
        if (timed_out !== 8'h00) begin n_fail++; $display("FAIL to_clear: timed_out got %h want 00", timed_out); end
    endtask

    task automatic test_recovery();
        host1_to_test_sent("rec");
        wait_tick();
        step();
        rx_msg = 1'b1; rx_host = 3'd1;
        step();
        rx_msg = 1'b0;
        wait_tick();
        step(); step();
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rec_t6: valid got %0b want 0", req_valid); end
        wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd1}) begin
            n_fail++;
            $display("FAIL rec_hb7: got v=%0b t=%0d h=%0d want v=1 t=1 h=1", req_valid, req_type, req_host);
        end
        wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, timed_out} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rec_t8: got v=%0b to=%h want v=0 to=00", req_valid, timed_out);
        end
        wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL rec_tr9: got v=%0b t=%0d h=%0d want v=1 t=2 h=1", req_valid, req_type, req_host);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_a [3];
        logic [2:0] exp_b [3];
        exp_a = '{3'd0, 3'd1, 3'd3};
        exp_b = '{3'd1, 3'd3, 3'd0};
        do_reset();
        hb_interval = 8'd3;
        req_ready = 1'b1;
        wait_tick();
        session_up = 8'b0000_1011;
        wait_tick(); wait_tick(); wait_tick();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, exp_a[k]}) begin
                n_fail++;
                $display("FAIL rr_a%0d: got v=%0b t=%0d h=%0d want v=1 t=1 h=%0d", k, req_valid, req_type, req_host, exp_a[k]);
            end
        end
        step();
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rr_a_idle: valid got %0b want 0", req_valid); end

        do_reset();
        req_ready = 1'b1;
        wait_tick();
        session_up = 8'b0000_0001;
        wait_tick(); wait_tick(); wait_tick();
        session_up = 8'b0000_1011;
        rx_msg = 1'b1; rx_host = 3'd0;
        step();
        rx_msg = 1'b0;
        step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL rr_ptr1: got v=%0b t=%0d h=%0d want v=1 t=1 h=0", req_valid, req_type, req_host);
        end
        wait_tick(); wait_tick(); wait_tick();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, exp_b[k]}) begin
                n_fail++;
                $display("FAIL rr_b%0d: got v=%0b t=%0d h=%0d want v=1 t=1 h=%0d", k, req_valid, req_type, req_host, exp_b[k]);
            end
        end
    endtask

    task automatic test_collision();
        int vcount = 0;
        do_reset();
        hb_interval = 8'd3;
        req_ready = 1'b1;
        wait_tick();
        session_up = 8'b0000_0001;
        wait_tick(); wait_tick(); wait_tick();
        tx_msg = 1'b1; tx_host = 3'd0;
        step();
        tx_msg = 1'b0;
        rx_msg = 1'b1; rx_host = 3'd0;
        step();
        rx_msg = 1'b0;
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL coll_nohb: valid got %0b want 0", req_valid); end
        wait_tick(); wait_tick();
        step(); step();
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL coll_t5: valid got %0b want 0", req_valid); end
        wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL coll_hb6: got v=%0b t=%0d h=%0d want v=1 t=1 h=0", req_valid, req_type, req_host);
        end

        do_reset();
        hb_interval = 8'd0;
        req_ready = 1'b1;
        session_up = 8'hFF;
        for (int c = 0; c < 80; c++) begin
            step();
            if (req_valid) vcount++;
        end
        n_tests++;
        if (vcount !== 0) begin n_fail++; $display("FAIL zero_interval: valid cycles got %0d want 0", vcount); end
        wait_tick();
        step();
        hb_interval = 8'd3;
        wait_tick(); wait_tick(); wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL zero_resume: got v=%0b t=%0d h=%0d want v=1 t=1 h=0", req_valid, req_type, req_host);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hb_interval = 8'd3;
        wait_tick();
        session_up = 8'b0000_0001;
        wait_tick(); wait_tick(); wait_tick();
        step(); step();
        n_tests++;
        if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre: valid got %0b want 1", req_valid); end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({req_valid, req_type, req_host, sec_tick, timed_out} !== 15'd0) begin
            n_fail++;
            $display("FAIL rm_async: got v=%0b t=%0d h=%0d tick=%0b to=%h want all 0",
                     req_valid, req_type, req_host, sec_tick, timed_out);
        end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            wait_tick();
            step(); step();
            n_tests++;
            if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_tick%0d: valid got %0b want 0", k, req_valid); end
        end
        wait_tick();
        step(); step();
        n_tests++;
        if ({req_valid, req_type, req_host} !== {1'b1, 2'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL rm_hb: got v=%0b t=%0d h=%0d want v=1 t=1 h=0", req_valid, req_type, req_host);
        end
    endtask

    initial begin
        rst = 1'b1;
        session_up = '0;
        hb_interval = 8'd3;
        rx_msg = 1'b0; rx_host = '0;
        tx_msg = 1'b0; tx_host = '0;
        req_ready = 1'b0;
        test_reset();
        test_heartbeat();
        test_timeout();
        test_recovery();
        test_round_robin();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
